// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences MULT/DIV/MFHI/MFLO requests to the multi-cycle multiply and
// divide units and owns architectural HI/LO. Define MULDIV_DIV_EN to enable the divider path.
module muldiv_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        req_ready,
  output logic        stall,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mult_start,
  input  logic        mult_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        div_start,
  input  logic        div_done,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        op_done,
  output logic        div_zero,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_DIV = 2'b01, OP_MFHI = 2'b10, OP_MFLO = 2'b11} op_t;

  state_t     state, state_next;
  logic       sel_div;
  logic [7:0] count;
  logic       accept, start_op, div_ok, done_sel, expired;

`ifdef MULDIV_DIV_EN
  assign div_ok   = (rt_val != '0);
  assign done_sel = sel_div ? div_done : mult_done;
`else
  // Divider absent: every DIV is reported through div_zero as unsupported.
  logic unused_div;
  assign unused_div = ^{div_done, div_hi, div_lo};
  assign div_ok     = 1'b0;
  assign done_sel   = mult_done;
`endif

  assign accept   = req_valid && req_ready;
  assign start_op = accept && ((req_op == OP_MULT) || ((req_op == OP_DIV) && div_ok));
  assign expired  = (count == 8'(TIMEOUT_CYCLES - 1));
  assign stall    = req_valid && !req_ready;

  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_op) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (done_sel || expired) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    mult_start = (state == START) && !sel_div;
`ifdef MULDIV_DIV_EN
    div_start  = (state == START) && sel_div;
`else
    div_start  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      hi          <= '0;
      lo          <= '0;
      unit_a      <= '0;
      unit_b      <= '0;
      rd_data     <= '0;
      count       <= '0;
      sel_div     <= 1'b0;
      rd_valid    <= 1'b0;
      op_done     <= 1'b0;
      div_zero    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rd_valid    <= 1'b0;
      op_done     <= 1'b0;
      div_zero    <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (op_t'(req_op))
              OP_MULT, OP_DIV: begin
                if (start_op) begin
                  unit_a  <= rs_val;
                  unit_b  <= rt_val;
                  sel_div <= (req_op == OP_DIV);
                end else begin
                  div_zero <= 1'b1;
                end
              end
              OP_MFHI: begin
                rd_data  <= hi;
                rd_valid <= 1'b1;
              end
              OP_MFLO: begin
                rd_data  <= lo;
                rd_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        START: count <= '0;
        WAIT: begin
          if (done_sel) begin
`ifdef MULDIV_DIV_EN
            hi <= sel_div ? div_hi : mult_hi;
            lo <= sel_div ? div_lo : mult_lo;
`else
            hi <= mult_hi;
            lo <= mult_lo;
`endif
            op_done <= 1'b1;
          end else if (expired) begin
            timeout_err <= 1'b1;
          end else begin
            count <= count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
